// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side handshake signals of the shared memory port
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              f_req, f_moc;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_rdata;
    logic              d_req, d_rw, d_size, d_moc;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic              err, busy;
    logic              mem_en, mem_rw, mem_size, mem_moc;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    modport slave (
        input  f_req, f_addr, d_req, d_rw, d_size, d_addr, d_wdata, mem_rdata, mem_moc,
        output f_moc, f_rdata, d_moc, d_rdata, err, busy, mem_en, mem_rw, mem_size, mem_addr, mem_wdata
    );
    modport master (
        output f_req, f_addr, d_req, d_rw, d_size, d_addr, d_wdata, mem_rdata, mem_moc,
        input  f_moc, f_rdata, d_moc, d_rdata, err, busy, mem_en, mem_rw, mem_size, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between fetch and data requesters
// Define MEM_TIMEOUT_EN to abort accesses whose mem_moc does not arrive within TIMEOUT cycles.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic            clk,
    input logic            reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t state;
    logic   owner, last_owner, grant_d;

    // owner/last_owner: 1 = data, 0 = fetch; on conflict the side that did not go last wins
    assign grant_d = bus.d_req & (~bus.f_req | ~last_owner);

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
`else
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= 1'b0;
            last_owner    <= 1'b0;
            bus.f_moc     <= 1'b0;
            bus.d_moc     <= 1'b0;
            bus.f_rdata   <= DATA_W'(0);
            bus.d_rdata   <= DATA_W'(0);
            bus.busy      <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_rw    <= 1'b0;
            bus.mem_size  <= 1'b0;
            bus.mem_addr  <= ADDR_W'(0);
            bus.mem_wdata <= DATA_W'(0);
`ifdef MEM_TIMEOUT_EN
            cnt           <= '0;
            bus.err       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.f_req | bus.d_req) begin
                    owner         <= grant_d;
                    last_owner    <= grant_d;
                    bus.mem_addr  <= grant_d ? bus.d_addr : bus.f_addr;
                    bus.mem_rw    <= grant_d & bus.d_rw;
                    bus.mem_size  <= grant_d & bus.d_size;
                    bus.mem_wdata <= grant_d ? bus.d_wdata : DATA_W'(0);
                    bus.mem_en    <= 1'b1;
                    bus.busy      <= 1'b1;
                    state         <= BUSY;
`ifdef MEM_TIMEOUT_EN
                    cnt           <= '0;
`endif
                end
                BUSY: if (bus.mem_moc) begin
                    bus.mem_en <= 1'b0;
                    if (owner) begin
                        bus.d_rdata <= bus.mem_rdata;
                        bus.d_moc   <= 1'b1;
                    end else begin
                        bus.f_rdata <= bus.mem_rdata;
                        bus.f_moc   <= 1'b1;
                    end
                    state <= RELEASE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt == CW'(TIMEOUT - 1)) begin
                    bus.mem_en <= 1'b0;
                    bus.err    <= 1'b1;
                    if (owner) begin
                        bus.d_rdata <= DATA_W'(0);
                        bus.d_moc   <= 1'b1;
                    end else begin
                        bus.f_rdata <= DATA_W'(0);
                        bus.f_moc   <= 1'b1;
                    end
                    state <= RELEASE;
                end else cnt <= cnt + 1'b1;
`endif
                RELEASE: begin
                    bus.f_moc <= 1'b0;
                    bus.d_moc <= 1'b0;
                    bus.busy  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                    bus.err   <= 1'b0;
`endif
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized accesses checked against a transaction-level model
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic last_d;                 // model: 1 if the previous grant went to data
    logic [31:0] exp_fr, exp_dr;  // model: held rdata per requester

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input string tag);
        chk({tag, "_fmoc"}, bus.f_moc, 0);
        chk({tag, "_dmoc"}, bus.d_moc, 0);
        chk({tag, "_en"}, bus.mem_en, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_frdata"}, bus.f_rdata, exp_fr);
        chk({tag, "_drdata"}, bus.d_rdata, exp_dr);
    endtask

    task automatic access(input logic fr, input logic dr, input logic rw, input logic sz,
                          input logic [31:0] fa, input logic [31:0] da, input logic [31:0] wd,
                          input logic [31:0] rd, input int lat);
        logic od;
        logic [31:0] ea;
        od = (fr && dr) ? !last_d : dr;
        last_d = od;
        ea = od ? da : fa;
        bus.f_req = fr; bus.d_req = dr; bus.f_addr = fa; bus.d_addr = da;
        bus.d_rw = rw; bus.d_size = sz; bus.d_wdata = wd;
        tick;
        chk("grant_en", bus.mem_en, 1);
        chk("grant_busy", bus.busy, 1);
        chk("grant_addr", bus.mem_addr, ea);
        chk("grant_rw", bus.mem_rw, od & rw);
        chk("grant_size", bus.mem_size, od & sz);
        if (od) chk("grant_wdata", bus.mem_wdata, wd);
        bus.f_addr = $urandom; bus.d_addr = $urandom; bus.d_rw = 1'($urandom);
        bus.d_size = 1'($urandom); bus.d_wdata = $urandom;
        for (int i = 1; i < lat; i++) begin
            tick;
            chk("wait_en", bus.mem_en, 1);
            chk("wait_addr", bus.mem_addr, ea);
            chk("wait_moc", {bus.f_moc, bus.d_moc}, 0);
        end
        bus.mem_moc = 1'b1; bus.mem_rdata = rd;
        tick;
        bus.mem_moc = 1'b0; bus.mem_rdata = $urandom; bus.f_req = 1'b0; bus.d_req = 1'b0;
        if (od) exp_dr = rd; else exp_fr = rd;
        chk("done_fmoc", bus.f_moc, !od);
        chk("done_dmoc", bus.d_moc, od);
        chk("done_frdata", bus.f_rdata, exp_fr);
        chk("done_drdata", bus.d_rdata, exp_dr);
        chk("done_en", bus.mem_en, 0);
        chk("done_busy", bus.busy, 1);
        chk("done_err", bus.err, 0);
        tick;
        quiet("release");
    endtask

    initial begin
        logic [1:0] r;
        reset = 1'b1;
        bus.f_req = 0; bus.f_addr = 0; bus.d_req = 0; bus.d_rw = 0; bus.d_size = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0; bus.mem_moc = 0;
        last_d = 1'b0; exp_fr = 0; exp_dr = 0;
        tick; tick;
        reset = 1'b0;
        quiet("reset");
        chk("reset_addr", bus.mem_addr, 0);
        chk("reset_wdata", bus.mem_wdata, 0);

        access(1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h8C220004, 3);
        access(0, 1, 1, 1, 32'h0, 32'h24, 32'hAB, 32'h5A5A5A5A, 2);

        // reset during the second BUSY cycle abandons the access
        bus.f_req = 1'b1; bus.f_addr = 32'h40;
        tick;
        tick;
        reset = 1'b1; bus.f_req = 1'b0;
        tick;
        reset = 1'b0; exp_fr = 0; exp_dr = 0; last_d = 1'b0;
        quiet("busy_reset");
        bus.mem_moc = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        tick;
        bus.mem_moc = 1'b0;
        quiet("stale_moc");

        // first conflicts after reset: DATA, FETCH, DATA
        access(1, 1, 0, 0, 32'h100, 32'h200, 32'h11, 32'hA1, 1);
        chk("order1", last_d, 1);
        access(1, 1, 1, 0, 32'h104, 32'h204, 32'h22, 32'hA2, 2);
        chk("order2", last_d, 0);
        access(1, 1, 0, 1, 32'h108, 32'h208, 32'h33, 32'hA3, 1);
        chk("order3", last_d, 1);

        // mem_moc while idle is ignored
        bus.mem_moc = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        tick;
        quiet("idle_moc1");
        tick;
        quiet("idle_moc2");
        bus.mem_moc = 1'b0;

`ifdef MEM_TIMEOUT_EN
        bus.d_req = 1'b1; bus.d_addr = 32'h300; bus.d_rw = 1'b0;
        tick;
        last_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("to_wait_en", bus.mem_en, 1);
            chk("to_wait_moc", bus.d_moc, 0);
        end
        tick;
        bus.d_req = 1'b0; exp_dr = 0;
        chk("to_dmoc", bus.d_moc, 1);
        chk("to_err", bus.err, 1);
        chk("to_drdata", bus.d_rdata, 0);
        chk("to_en", bus.mem_en, 0);
        chk("to_fmoc", bus.f_moc, 0);
        tick;
        quiet("to_release");
        access(1, 0, 0, 0, 32'h44, 32'h0, 32'h0, 32'h77, 4);
`else
        access(0, 1, 0, 0, 32'h0, 32'h48, 32'h0, 32'h99, 12);
`endif

        for (int n = 0; n < 30; n++) begin
            r = 2'($urandom_range(1, 3));
            access(r[0], r[1], 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                   $urandom, int'($urandom_range(1, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
